// File: rtl/delay_monitor.sv
// delay_monitor: receive-side checker for a periodic single-cycle pulse.
// Measures pulse-to-pulse spacing, locks after LOCK_CNT good gaps in a row,
// and raises a sticky error on an early or missing pulse once locked.
module delay_monitor #(
  parameter int PERIOD   = 2501,
  parameter int CBITS    = 12,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             ack,
  output logic             lock,
  output logic             err,
  output logic             early,
  output logic             late,
  output logic [CBITS-1:0] last_gap
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED,
    ALARM
  } state_e;

  localparam logic [CBITS-1:0] GAP_LO = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] GAP_HI = CBITS'(PERIOD + TOL);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [3:0]       good_q, good_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic [CBITS-1:0] last_gap_q, last_gap_d;

  logic             gap_good;
  logic             gap_early;
  logic             timeout;
  logic [3:0]       good_inc;

  // Gap classification against the current counter value.
  always_comb begin
    gap_good  = sig && (cnt_q >= GAP_LO) && (cnt_q <= GAP_HI);
    gap_early = sig && (cnt_q < GAP_LO);
    timeout   = !sig && (cnt_q == GAP_HI);
    good_inc  = good_q + 4'd1;
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    err_d      = err_q;
    early_d    = 1'b0;
    late_d     = 1'b0;
    last_gap_d = last_gap_q;

    // Counter restarts on every pulse in every state and saturates otherwise.
    if (sig) begin
      cnt_d = CBITS'(1);
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CBITS'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (sig) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (sig) begin
          last_gap_d = cnt_q;
        end
        if (gap_good) begin
          good_d = good_inc;
          if (good_inc == LOCK_N) begin
            state_d = LOCKED;
          end
        end else if (gap_early) begin
          early_d = 1'b1;
          good_d  = '0;
        end else if (timeout) begin
          late_d  = 1'b1;
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (sig) begin
          last_gap_d = cnt_q;
        end
        if (gap_early) begin
          early_d = 1'b1;
          err_d   = 1'b1;
          state_d = ALARM;
        end else if (timeout) begin
          late_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ALARM;
        end
      end
      ALARM: begin
        // A pulse coinciding with ack only restarts the counter.
        if (ack) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    lock_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_q     <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      last_gap_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      early_q    <= early_d;
      late_q     <= late_d;
      last_gap_q <= last_gap_d;
    end
  end

  assign lock     = lock_q;
  assign err      = err_q;
  assign early    = early_q;
  assign late     = late_q;
  assign last_gap = last_gap_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Scoreboard bench for delay_monitor: stimulus queues hand-computed output
// snapshots for given cycles, a negedge monitor pops and compares them.
module tb_delay_monitor;

  logic       clk;
  logic       rst;
  logic       sig;
  logic       ack;
  logic       lock;
  logic       err;
  logic       early;
  logic       late;
  logic [3:0] last_gap;

  delay_monitor #(
    .PERIOD  (10),
    .CBITS   (4),
    .TOL     (1),
    .LOCK_CNT(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sig     (sig),
    .ack     (ack),
    .lock    (lock),
    .err     (err),
    .early   (early),
    .late    (late),
    .last_gap(last_gap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string name;
    logic  lock;
    logic  err;
    logic  early;
    logic  late;
    int    gap;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   base   = 0;

  // Monitor: compare outputs against queued expectations for this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act_v;
    logic [7:0] exp_v;
    n_vec++;
    if (early && late) begin
      n_fail++;
      $display("FAIL early_late_excl cyc=%0d got early=%0b late=%0b required not both", cyc, early, late);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
      end else begin
        act_v = {lock, err, early, late, last_gap};
        exp_v = {e.lock, e.err, e.early, e.late, 4'(e.gap)};
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got lock/err/early/late/gap=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                   e.name, cyc - base, lock, err, early, late, last_gap,
                   e.lock, e.err, e.early, e.late, e.gap);
        end
        if (e.cnt >= 0) begin
          n_vec++;
          if (dut.cnt_q !== 4'(e.cnt)) begin
            n_fail++;
            $display("FAIL %s_cnt cyc=%0d got cnt=%0d required %0d", e.name, cyc - base, dut.cnt_q, e.cnt);
          end
        end
      end
    end
  end

  function automatic void ex(input int t, input string nm, input logic l, input logic e,
                             input logic ea, input logic la, input int g, input int c = -1);
    exp_t x;
    x.cyc = base + t; x.name = nm; x.lock = l; x.err = e;
    x.early = ea; x.late = la; x.gap = g; x.cnt = c;
    sb.push_back(x);
  endfunction

  task automatic drive(input logic s, input logic a, input logic r);
    sig = s; ack = a; rst = r;
    @(negedge clk);
  endtask

  task automatic idle_to(input int t);
    while (cyc < base + t) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_at(input int t);
    idle_to(t);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    base = cyc;
  endtask

  initial begin
    sig = 1'b0; ack = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Lock, tolerance edges, early pulse while locked, ALARM hold, ack.
    do_reset();
    ex(0,  "reset",      0, 0, 0, 0, 0);
    ex(6,  "idle_pulse", 0, 0, 0, 0, 0);
    ex(35, "pre_lock",   0, 0, 0, 0, 10);
    ex(36, "lock",       1, 0, 0, 0, 10);
    ex(45, "gap9",       1, 0, 0, 0, 9);
    ex(56, "gap11",      1, 0, 0, 0, 11);
    ex(64, "gap8_early", 0, 1, 1, 0, 8);
    ex(65, "early_1cyc", 0, 1, 0, 0, 8);
    ex(71, "alarm_ign",  0, 1, 0, 0, 8);
    ex(80, "alarm_hold", 0, 1, 0, 0, 8);
    ex(82, "ack_clear",  0, 0, 0, 0, 8);
    pulse_at(5); pulse_at(15); pulse_at(25); pulse_at(35);
    pulse_at(44); pulse_at(55); pulse_at(63); pulse_at(70);
    idle_to(81);
    drive(1'b0, 1'b1, 1'b0);
    idle_to(84);

    // Missing pulse while locked, ack, then relock from IDLE.
    do_reset();
    ex(31, "lock2",       1, 0, 0, 0, 10);
    ex(41, "pre_late",    1, 0, 0, 0, 10);
    ex(42, "late",        0, 1, 0, 1, 10);
    ex(43, "late_1cyc",   0, 1, 0, 0, 10);
    ex(46, "ack2",        0, 0, 0, 0, 10);
    ex(71, "relock_pend", 0, 0, 0, 0, 10);
    ex(81, "relock",      1, 0, 0, 0, 10);
    pulse_at(0); pulse_at(10); pulse_at(20); pulse_at(30);
    idle_to(45);
    drive(1'b0, 1'b1, 1'b0);
    pulse_at(50); pulse_at(60); pulse_at(70); pulse_at(80);
    idle_to(83);

    // Early pulse in TRACK restarts the good count; reset while locked.
    do_reset();
    ex(15, "trk_early",      0, 0, 1, 0, 4);
    ex(16, "trk_early_1cyc", 0, 0, 0, 0, 4);
    ex(35, "trk_pend",       0, 0, 0, 0, 10);
    ex(45, "trk_lock",       1, 0, 0, 0, 10);
    ex(48, "rst_locked",     0, 0, 0, 0, 0, 0);
    pulse_at(0); pulse_at(10); pulse_at(14);
    pulse_at(24); pulse_at(34); pulse_at(44);
    idle_to(47);
    drive(1'b1, 1'b1, 1'b1);

    // ack together with sig in ALARM must not start TRACK.
    do_reset();
    ex(31, "lock5",       1, 0, 0, 0, 10);
    ex(36, "early_lkd",   0, 1, 1, 0, 5);
    ex(41, "acksig",      0, 0, 0, 0, 5);
    ex(71, "acksig_pend", 0, 0, 0, 0, 10);
    ex(81, "acksig_lock", 1, 0, 0, 0, 10);
    pulse_at(0); pulse_at(10); pulse_at(20); pulse_at(30); pulse_at(35);
    idle_to(40);
    drive(1'b1, 1'b1, 1'b0);
    pulse_at(50); pulse_at(60); pulse_at(70); pulse_at(80);
    idle_to(83);

    // Counter saturation in IDLE, then timeout in TRACK returns to IDLE.
    do_reset();
    ex(20, "sat20",         0, 0, 0, 0, 0, 15);
    ex(40, "sat40",         0, 0, 0, 0, 0, 15);
    ex(46, "trk_start",     0, 0, 0, 0, 0, 1);
    ex(56, "pre_to",        0, 0, 0, 0, 0, 11);
    ex(57, "trk_late",      0, 0, 0, 1, 0);
    ex(58, "trk_late_1cyc", 0, 0, 0, 0, 0);
    pulse_at(45);
    idle_to(60);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations never checked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_monitor.md
# delay_monitor

Receive-side checker for the periodic `sig` pulse produced by the delay/pulse generator. It measures the spacing between consecutive single-cycle pulses and locks after a run of correctly spaced pulses. Once locked, any early or missing pulse raises a sticky error. It sits next to the generator, or at the far end of the `sig` wire, and supplies lock and fault status to the supervisory logic.

## Interface
Parameters:
- `PERIOD`, 2501: nominal spacing in clock cycles from one `sig` pulse to the next.
- `CBITS`, 12: width of the gap counter and of `last_gap`. Requires 2^CBITS − 1 ≥ PERIOD + TOL.
- `TOL`, 2: allowed deviation in cycles, applied symmetrically.
- `LOCK_CNT`, 4: number of consecutive good gaps needed to reach lock. Range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig`  in  1  pulse input, one cycle wide when the generator is correct.
- `ack`  in  1  clears ALARM and returns the block to IDLE.
- `lock` out 1  high while in LOCKED.
- `err`  out 1  sticky fault flag; set on entry to ALARM.
- `early` out 1  one-cycle pulse: the last gap was shorter than PERIOD − TOL.
- `late` out 1  one-cycle pulse: no pulse arrived by the PERIOD + TOL deadline.
- `last_gap` out CBITS  most recently measured gap.

## Operation
Gap counter `cnt`:
- On a cycle with `sig` = 1, the next value of `cnt` is 1.
- Otherwise `cnt` increments and saturates at all-ones.
- At a pulse in cycle t, the measured gap is the value of `cnt` in cycle t.
- Gap classes:
  - good: PERIOD − TOL ≤ gap ≤ PERIOD + TOL.
  - early: gap < PERIOD − TOL.
  - timeout: `cnt` == PERIOD + TOL and `sig` = 0 in the same cycle.

State machine (`good` is a 4-bit count of consecutive good gaps):
- IDLE:
  - `sig` → TRACK, `good` = 0, `cnt` restarts.
  - No gap is measured and `last_gap` is unchanged.
- TRACK:
  - good gap → `good` + 1. When the new value equals LOCK_CNT, go to LOCKED.
  - early gap → pulse `early`, set `good` = 0, stay in TRACK; the gap restarts from this pulse.
  - timeout → pulse `late`, go to IDLE.
- LOCKED:
  - good gap → stay.
  - early gap or timeout → pulse `early` or `late` respectively, set `err` = 1, go to ALARM.
- ALARM:
  - `sig` is ignored apart from the `cnt` restart.
  - `ack` → IDLE and `err` = 0.
  - `ack` and `sig` in the same cycle → IDLE; that `sig` does not start TRACK.

Output rules:
- `last_gap` updates on every pulse taken in TRACK or LOCKED.
- `rst` overrides `ack`, `sig` and any operation in progress, from any state.
- `early` and `late` never assert in the same cycle.
- A `sig` held high across several cycles counts as a pulse on each cycle. Each such pulse sees gap 1, which is early.

## Timing
- All outputs are registered. Reset value of every output is 0; state = IDLE, `cnt` = 0, `good` = 0.
- Pulse at cycle t classified as good or early → `early`, `last_gap`, `lock` and `err` change at cycle t+1.
- Timeout detected at cycle t → `late` = 1 at cycle t+1 only.
- Lock latency: `lock` rises one cycle after the pulse that ends the LOCK_CNT-th good gap.
- `lock` falls in the same cycle that `err` rises.
- `ack` at cycle t → `err` = 0 at t+1.
- Saturation: `cnt` never wraps. In IDLE or ALARM with no pulses it holds at all-ones.

## Test plan
Bench parameters: PERIOD = 10, TOL = 1, LOCK_CNT = 3, CBITS = 4.
- Lock: pulses at cycles 5, 15, 25, 35 → `lock` = 1 at cycle 36; `last_gap` = 10; `early`, `late` and `err` stay 0.
- Tolerance edges:
  - After lock, gaps of 9 and 11 → stay LOCKED with no pulses on `early`/`late`.
  - Gap of 8 → `early` = 1 for one cycle, `err` = 1, `lock` = 0, `last_gap` = 8.
- Missing pulse: lock, then the next pulse is withheld → `late` = 1 exactly 12 cycles after the last pulse, `err` = 1; `ack` → `err` = 0 the next cycle and state is IDLE.
- Early pulse in TRACK:
  - Pulses at 0, 10, 14 → `early` at 15, no `err`.
  - Then pulses at 24, 34, 44 → `lock` = 1 at 45, since the good count restarted from the pulse at 14.
- Reset and `ack` priority:
  - `rst` asserted while LOCKED → all outputs 0 the next cycle.
  - In ALARM, `ack` and `sig` together → IDLE; a following correct pulse train needs LOCK_CNT + 1 pulses to lock.
- Saturation: no pulses for 40 cycles after reset → `cnt` holds at 15 and no outputs assert.
